// File: rtl/dmem_access_unit_pkg.sv
// Shared encodings for the data-memory access unit: load/store size codes,
// access FSM state codes and byte-enable constants.
package dmem_access_unit_pkg;

   localparam logic [2:0] DM_WORD   = 3'b000;
   localparam logic [2:0] DM_HALF   = 3'b001;
   localparam logic [2:0] DM_HALF_U = 3'b010;
   localparam logic [2:0] DM_BYTE   = 3'b011;
   localparam logic [2:0] DM_BYTE_U = 3'b100;

   typedef enum logic [1:0] {
      DMA_IDLE = 2'd0,
      DMA_REQ  = 2'd1,
      DMA_DONE = 2'd2
   } dma_state_e;

   localparam logic [3:0] BE_NONE    = 4'b0000;
   localparam logic [3:0] BE_WORD    = 4'b1111;
   localparam logic [3:0] BE_HALF_LO = 4'b0011;
   localparam logic [3:0] BE_HALF_HI = 4'b1100;
   localparam logic [3:0] BE_BYTE0   = 4'b0001;

   // Codes outside the defined set fall into the word rule.
   function automatic logic is_misaligned(input logic [2:0] ctrl, input logic [1:0] off);
      case (ctrl)
         DM_HALF, DM_HALF_U: return off[0];
         DM_BYTE, DM_BYTE_U: return 1'b0;
         default:            return |off;
      endcase
   endfunction

endpackage

// File: rtl/dmem_access_unit_lane_align.sv
// Combinational lane steering: store byte-enables and replicated write data,
// plus load extraction with sign/zero extension from the raw memory word.
module dmem_lane_align
   import dmem_access_unit_pkg::*;
(
   input  logic [2:0]  i_st_ctrl,
   input  logic [1:0]  i_st_off,
   input  logic [31:0] i_st_data,
   output logic [3:0]  o_st_be,
   output logic [31:0] o_st_data,
   input  logic [2:0]  i_ld_ctrl,
   input  logic [1:0]  i_ld_off,
   input  logic [31:0] i_ld_raw,
   output logic [31:0] o_ld_data
);

   logic [31:0] w_ld_shift;

   always_comb begin
      o_st_be   = BE_WORD;
      o_st_data = i_st_data;
      case (i_st_ctrl)
         DM_HALF, DM_HALF_U: begin
            o_st_be   = i_st_off[1] ? BE_HALF_HI : BE_HALF_LO;
            o_st_data = {2{i_st_data[15:0]}};
         end
         DM_BYTE, DM_BYTE_U: begin
            o_st_be   = BE_BYTE0 << i_st_off;
            o_st_data = {4{i_st_data[7:0]}};
         end
         default: ;
      endcase
   end

   assign w_ld_shift = i_ld_raw >> {i_ld_off, 3'b000};

   always_comb begin
      o_ld_data = w_ld_shift;
      case (i_ld_ctrl)
         DM_HALF:   o_ld_data = {{16{w_ld_shift[15]}}, w_ld_shift[15:0]};
         DM_HALF_U: o_ld_data = {16'h0000, w_ld_shift[15:0]};
         DM_BYTE:   o_ld_data = {{24{w_ld_shift[7]}}, w_ld_shift[7:0]};
         DM_BYTE_U: o_ld_data = {24'h000000, w_ld_shift[7:0]};
         default: ;
      endcase
   end

endmodule

// File: rtl/dmem_access_unit.sv
// MEM-stage data-memory access unit: req/ack handshake to a variable-latency
// word memory, pipeline stall generation, ack timeout and lane handling.
//
// state    | meaning
// ---------+------------------------------------------------------------
// DMA_IDLE | no access; stall while a valid request is presented, launch it
// DMA_REQ  | mem_req held; wait for ack or timeout, counter running
// DMA_DONE | one cycle, load data / bus_err presented, stall released
module dmem_access_unit
   import dmem_access_unit_pkg::*;
#(
   parameter int unsigned ACK_TIMEOUT = 255,
   parameter int unsigned TMO_W       = 8
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_cpu_mem_w,
   input  logic        i_cpu_mem_r,
   input  logic [31:0] i_cpu_addr,
   input  logic [31:0] i_cpu_wdata,
   input  logic [2:0]  i_cpu_dm_ctrl,
   output logic [31:0] o_cpu_rdata,
   output logic        o_cpu_stall,
   output logic        o_cpu_misalign,
   output logic        o_bus_err,
   output logic        o_mem_req,
   output logic        o_mem_we,
   output logic [31:0] o_mem_addr,
   output logic [31:0] o_mem_wdata,
   output logic [3:0]  o_mem_be,
   input  logic        i_mem_ack,
   input  logic [31:0] i_mem_rdata
);

   dma_state_e r_state, w_state_nxt;

   logic [TMO_W-1:0] r_cnt;
   logic             r_err;
   logic [31:0]      r_rdata;
   logic             r_mem_req;
   logic             r_mem_we;
   logic [31:0]      r_mem_addr;
   logic [31:0]      r_mem_wdata;
   logic [3:0]       r_mem_be;
   logic [2:0]       r_ld_ctrl;
   logic [1:0]       r_ld_off;

   logic        w_any;
   logic        w_misalign;
   logic        w_valid;
   logic        w_stall;
   logic        w_launch;
   logic        w_ack_hit;
   logic        w_tmo;
   logic [3:0]  w_st_be;
   logic [31:0] w_st_data;
   logic [31:0] w_ld_data;

   assign w_any      = i_cpu_mem_w | i_cpu_mem_r;
   assign w_misalign = w_any & is_misaligned(i_cpu_dm_ctrl, i_cpu_addr[1:0]);
   assign w_valid    = w_any & ~w_misalign;

   dmem_lane_align u_lane_align (
      .i_st_ctrl (i_cpu_dm_ctrl),
      .i_st_off  (i_cpu_addr[1:0]),
      .i_st_data (i_cpu_wdata),
      .o_st_be   (w_st_be),
      .o_st_data (w_st_data),
      .i_ld_ctrl (r_ld_ctrl),
      .i_ld_off  (r_ld_off),
      .i_ld_raw  (i_mem_rdata),
      .o_ld_data (w_ld_data)
   );

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) r_state <= DMA_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_stall     = 1'b0;
      w_launch    = 1'b0;
      w_ack_hit   = 1'b0;
      w_tmo       = 1'b0;
      case (r_state)
         DMA_IDLE: begin
            w_stall = w_valid;
            if (w_valid) begin
               w_launch    = 1'b1;
               w_state_nxt = DMA_REQ;
            end
         end
         DMA_REQ: begin
            w_stall = 1'b1;
            if (i_mem_ack) begin
               w_ack_hit   = 1'b1;
               w_state_nxt = DMA_DONE;
            end else if (r_cnt == TMO_W'(ACK_TIMEOUT - 1)) begin
               w_tmo       = 1'b1;
               w_state_nxt = DMA_DONE;
            end
         end
         DMA_DONE: w_state_nxt = DMA_IDLE;
         default:  w_state_nxt = DMA_IDLE;
      endcase
   end

   // Both strobes set is a write; reads carry no byte enables.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_cnt       <= '0;
         r_err       <= 1'b0;
         r_rdata     <= '0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_mem_be    <= BE_NONE;
         r_ld_ctrl   <= DM_WORD;
         r_ld_off    <= 2'b00;
      end else begin
         if (w_launch) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= i_cpu_mem_w;
            r_mem_addr  <= {i_cpu_addr[31:2], 2'b00};
            r_mem_wdata <= i_cpu_mem_w ? w_st_data : '0;
            r_mem_be    <= i_cpu_mem_w ? w_st_be : BE_NONE;
            r_ld_ctrl   <= i_cpu_dm_ctrl;
            r_ld_off    <= i_cpu_addr[1:0];
            r_cnt       <= '0;
         end
         if (r_state == DMA_REQ) begin
            r_cnt <= r_cnt + TMO_W'(1);
            if (w_ack_hit || w_tmo) begin
               r_mem_req   <= 1'b0;
               r_mem_we    <= 1'b0;
               r_mem_addr  <= '0;
               r_mem_wdata <= '0;
               r_mem_be    <= BE_NONE;
               r_rdata     <= w_ack_hit ? w_ld_data : '0;
               r_err       <= w_tmo;
            end
         end
         if (r_state == DMA_DONE) begin
            r_cnt <= '0;
            r_err <= 1'b0;
         end
      end
   end

   assign o_cpu_rdata    = r_rdata;
   assign o_cpu_stall    = w_stall;
   assign o_cpu_misalign = w_misalign;
   assign o_bus_err      = (r_state == DMA_DONE) & r_err;
   assign o_mem_req      = r_mem_req;
   assign o_mem_we       = r_mem_we;
   assign o_mem_addr     = r_mem_addr;
   assign o_mem_wdata    = r_mem_wdata;
   assign o_mem_be       = r_mem_be;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Bench for dmem_access_unit: directed scenarios plus randomized accesses
// against a size/offset arithmetic reference model.
module tb_dmem_access_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        sel = 1'b0;
   logic        cpu_w = 1'b0, cpu_r = 1'b0;
   logic [31:0] cpu_addr = '0, cpu_wdata = '0, mem_rdata = '0;
   logic [2:0]  cpu_ctrl = '0;
   logic        ack0 = 1'b0, ack1 = 1'b0;

   logic [31:0] rd0, rd1, ma0, ma1, mw0, mw1;
   logic        st0, st1, mis0, mis1, be0e, be1e, rq0, rq1, we0, we1;
   logic [3:0]  mb0, mb1;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   dmem_access_unit dut (
      .i_clk(clk), .i_rst(rst),
      .i_cpu_mem_w(cpu_w & ~sel), .i_cpu_mem_r(cpu_r & ~sel),
      .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata), .i_cpu_dm_ctrl(cpu_ctrl),
      .o_cpu_rdata(rd0), .o_cpu_stall(st0), .o_cpu_misalign(mis0), .o_bus_err(be0e),
      .o_mem_req(rq0), .o_mem_we(we0), .o_mem_addr(ma0), .o_mem_wdata(mw0), .o_mem_be(mb0),
      .i_mem_ack(ack0), .i_mem_rdata(mem_rdata)
   );

   dmem_access_unit #(.ACK_TIMEOUT(4), .TMO_W(8)) dut_t (
      .i_clk(clk), .i_rst(rst),
      .i_cpu_mem_w(cpu_w & sel), .i_cpu_mem_r(cpu_r & sel),
      .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata), .i_cpu_dm_ctrl(cpu_ctrl),
      .o_cpu_rdata(rd1), .o_cpu_stall(st1), .o_cpu_misalign(mis1), .o_bus_err(be1e),
      .o_mem_req(rq1), .o_mem_we(we1), .o_mem_addr(ma1), .o_mem_wdata(mw1), .o_mem_be(mb1),
      .i_mem_ack(ack1), .i_mem_rdata(mem_rdata)
   );

   // Observed view of whichever instance is selected.
   wire        s_stall = sel ? st1 : st0;
   wire        s_req   = sel ? rq1 : rq0;
   wire        s_we    = sel ? we1 : we0;
   wire        s_err   = sel ? be1e : be0e;
   wire        s_mis   = sel ? mis1 : mis0;
   wire [31:0] s_rdata = sel ? rd1 : rd0;
   wire [31:0] s_addr  = sel ? ma1 : ma0;
   wire [31:0] s_wdata = sel ? mw1 : mw0;
   wire [3:0]  s_be    = sel ? mb1 : mb0;

   // ---------------- reference model ----------------
   function automatic int size_of(input logic [2:0] c);
      if (c == 3'd1 || c == 3'd2) return 2;
      if (c == 3'd3 || c == 3'd4) return 1;
      return 4;
   endfunction

   function automatic logic [3:0] m_be(input logic [2:0] c, input logic [31:0] a);
      int sz = size_of(c);
      int off = int'(a % 4);
      if (sz == 4) return 4'hF;
      if (sz == 2) return 4'(3 << off);
      return 4'(1 << off);
   endfunction

   function automatic logic [31:0] m_wdata(input logic [2:0] c, input logic [31:0] d);
      int sz = size_of(c);
      if (sz == 1) return (d % 256) * 32'h01010101;
      if (sz == 2) return (d % 65536) * 32'h00010001;
      return d;
   endfunction

   function automatic logic [31:0] m_load(input logic [2:0] c, input logic [31:0] a, input logic [31:0] raw);
      int sz = size_of(c);
      logic [31:0] v = raw / (32'd1 << (8 * (a % 4)));
      if (sz == 1) begin
         v = v % 256;
         if (c == 3'd3 && v >= 128) v = v + 32'hFFFFFF00;
      end else if (sz == 2) begin
         v = v % 65536;
         if (c == 3'd1 && v >= 32768) v = v + 32'hFFFF0000;
      end
      return v;
   endfunction

   // Presents one request, acks on REQ cycle number dly (0 = never), runs until DONE.
   task automatic run_access(
      input bit s, input bit w, input bit r, input logic [31:0] a, input logic [31:0] d,
      input logic [2:0] c, input int dly, input logic [31:0] raw,
      output int n_stall, output int n_req, output logic [3:0] be_o, output logic [31:0] wd_o,
      output logic [31:0] ad_o, output logic we_o, output logic [31:0] rd_o, output logic err_o,
      output logic mis_o, output bit stable, output bit clean, output bit hung);
      bit done = 0;
      n_stall = 0; n_req = 0; be_o = '0; wd_o = '0; ad_o = '0; we_o = 0;
      rd_o = '0; err_o = 0; mis_o = 0; stable = 1; clean = 1; hung = 0;
      @(posedge clk); #1;
      sel = s; cpu_w = w; cpu_r = r; cpu_addr = a; cpu_wdata = d; cpu_ctrl = c;
      mem_rdata = raw; ack0 = 0; ack1 = 0;
      for (int k = 0; k < 600 && !done; k++) begin
         @(negedge clk);
         if (k == 0) mis_o = s_mis;
         if (s_stall) n_stall++;
         if (s_req) begin
            if (n_req == 0) begin
               be_o = s_be; wd_o = s_wdata; ad_o = s_addr; we_o = s_we;
            end else if (be_o !== s_be || wd_o !== s_wdata || ad_o !== s_addr || we_o !== s_we) begin
               stable = 0;
            end
            n_req++;
            if (s) ack1 = (dly != 0 && n_req == dly);
            else   ack0 = (dly != 0 && n_req == dly);
         end else begin
            ack0 = 0; ack1 = 0;
            if (!s_stall) begin
               if (n_req > 0) begin
                  rd_o = s_rdata; err_o = s_err;
                  if (s_we !== 1'b0 || s_be !== 4'h0 || s_wdata !== 32'h0 || s_addr !== 32'h0) clean = 0;
               end
               done = 1;
            end
         end
      end
      if (!done) hung = 1;
      @(posedge clk); #1;
      cpu_w = 0; cpu_r = 0; ack0 = 0; ack1 = 0;
   endtask

   int ns, nr;
   logic [3:0] obe;
   logic [31:0] owd, oad, ord;
   logic owe, oerr, omis;
   bit ostab, oclean, ohung;

   task automatic test_reset();
      rst = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({rq0, we0, st0, be0e, mis0} !== 5'b0 || ma0 !== 0 || mw0 !== 0 || mb0 !== 0 || rd0 !== 0) begin
         failures++;
         $display("FAIL reset_outputs got req=%b we=%b stall=%b err=%b addr=%h wd=%h be=%h rd=%h exp all zero",
                  rq0, we0, st0, be0e, ma0, mw0, mb0, rd0);
      end
      rst = 1;
      @(negedge clk);
   endtask

   task automatic test_sb();
      run_access(0, 1, 0, 32'h1003, 32'h000000AB, 3'b011, 1, 32'h0,
                 ns, nr, obe, owd, oad, owe, ord, oerr, omis, ostab, oclean, ohung);
      checks++; if (ohung) begin failures++; $display("FAIL sb_timeout got=hung exp=done"); end
      checks++; if (obe !== 4'b1000) begin failures++; $display("FAIL sb_be got=%b exp=1000", obe); end
      checks++; if (owd !== 32'hABABABAB) begin failures++; $display("FAIL sb_wdata got=%h exp=ababab ab", owd); end
      checks++; if (oad !== 32'h1000) begin failures++; $display("FAIL sb_addr got=%h exp=00001000", oad); end
      checks++; if (ns !== 2) begin failures++; $display("FAIL sb_stalls got=%0d exp=2", ns); end
      checks++; if (owe !== 1'b1) begin failures++; $display("FAIL sb_we got=%b exp=1", owe); end
   endtask

   task automatic test_lh_lhu();
      run_access(0, 0, 1, 32'h2002, 32'h0, 3'b001, 1, 32'h80011234,
                 ns, nr, obe, owd, oad, owe, ord, oerr, omis, ostab, oclean, ohung);
      checks++; if (ord !== 32'hFFFF8001) begin failures++; $display("FAIL lh_rdata got=%h exp=ffff8001", ord); end
      checks++; if (obe !== 4'b0000) begin failures++; $display("FAIL lh_be got=%b exp=0000", obe); end
      run_access(0, 0, 1, 32'h2002, 32'h0, 3'b010, 2, 32'h80011234,
                 ns, nr, obe, owd, oad, owe, ord, oerr, omis, ostab, oclean, ohung);
      checks++; if (ord !== 32'h00008001) begin failures++; $display("FAIL lhu_rdata got=%h exp=00008001", ord); end
   endtask

   task automatic test_lw_latency();
      run_access(0, 0, 1, 32'h3000, 32'h0, 3'b000, 5, 32'hDEADBEEF,
                 ns, nr, obe, owd, oad, owe, ord, oerr, omis, ostab, oclean, ohung);
      checks++; if (ns !== 6) begin failures++; $display("FAIL lw_stalls got=%0d exp=6", ns); end
      checks++; if (nr !== 5) begin failures++; $display("FAIL lw_req_cycles got=%0d exp=5", nr); end
      checks++; if (ord !== 32'hDEADBEEF) begin failures++; $display("FAIL lw_rdata got=%h exp=deadbeef", ord); end
      checks++; if (!ostab || !oclean) begin failures++; $display("FAIL lw_hold got stable=%b clean=%b exp=1 1", ostab, oclean); end
      @(negedge clk);
      checks++; if (rd0 !== 32'hDEADBEEF) begin failures++; $display("FAIL lw_rdata_hold got=%h exp=deadbeef", rd0); end
   endtask

   task automatic test_misalign();
      run_access(0, 1, 0, 32'h4002, 32'h12345678, 3'b000, 1, 32'h0,
                 ns, nr, obe, owd, oad, owe, ord, oerr, omis, ostab, oclean, ohung);
      checks++; if (omis !== 1'b1) begin failures++; $display("FAIL sw_misalign got=%b exp=1", omis); end
      checks++; if (nr !== 0 || ns !== 0) begin failures++; $display("FAIL sw_misalign_txn got req=%0d stall=%0d exp=0 0", nr, ns); end
   endtask

   task automatic test_timeout();
      run_access(1, 0, 1, 32'h7000, 32'h0, 3'b000, 0, 32'hFFFFFFFF,
                 ns, nr, obe, owd, oad, owe, ord, oerr, omis, ostab, oclean, ohung);
      sel = 1;
      checks++; if (nr !== 4) begin failures++; $display("FAIL tmo_req_cycles got=%0d exp=4", nr); end
      checks++; if (oerr !== 1'b1) begin failures++; $display("FAIL tmo_bus_err got=%b exp=1", oerr); end
      checks++; if (ord !== 32'h0) begin failures++; $display("FAIL tmo_rdata got=%h exp=00000000", ord); end
      @(negedge clk);
      checks++; if (be1e !== 1'b0) begin failures++; $display("FAIL tmo_err_pulse got=%b exp=0", be1e); end
      sel = 0;
   endtask

   task automatic test_reset_mid();
      @(posedge clk); #1;
      sel = 0; cpu_r = 1; cpu_addr = 32'h5000; cpu_ctrl = 3'b000; ack0 = 0;
      repeat (3) @(negedge clk);
      checks++; if (rq0 !== 1'b1) begin failures++; $display("FAIL rstmid_in_req got=%b exp=1", rq0); end
      rst = 0; cpu_r = 0;
      #1;
      checks++; if (rq0 !== 1'b0 || st0 !== 1'b0 || mb0 !== 4'h0 || ma0 !== 0) begin
         failures++; $display("FAIL rstmid_clear got req=%b stall=%b be=%h addr=%h exp=0", rq0, st0, mb0, ma0);
      end
      @(negedge clk); rst = 1;
      @(negedge clk); ack0 = 1;
      @(negedge clk); ack0 = 0;
      checks++; if (rq0 !== 1'b0 || st0 !== 1'b0) begin
         failures++; $display("FAIL rstmid_stale_ack got req=%b stall=%b exp=0 0", rq0, st0);
      end
      run_access(0, 0, 1, 32'h6001, 32'h0, 3'b011, 2, 32'h00008000,
                 ns, nr, obe, owd, oad, owe, ord, oerr, omis, ostab, oclean, ohung);
      checks++; if (ord !== 32'hFFFFFF80 || nr !== 2 || ns !== 3) begin
         failures++; $display("FAIL rstmid_lb got rd=%h req=%0d stall=%0d exp=ffffff80 2 3", ord, nr, ns);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 60; i++) begin
         logic [2:0] c = 3'($urandom_range(0, 7));
         logic [31:0] a = $urandom;
         logic [31:0] d = $urandom;
         logic [31:0] raw = $urandom;
         bit w = 1'($urandom_range(0, 1));
         bit r = 1'($urandom_range(0, 1));
         int dly = $urandom_range(1, 6);
         bit any = w | r;
         bit mis = any && ((a % size_of(c)) != 0);
         run_access(0, w, r, a, d, c, dly, raw,
                    ns, nr, obe, owd, oad, owe, ord, oerr, omis, ostab, oclean, ohung);
         checks++;
         if (omis !== mis) begin failures++; $display("FAIL rnd%0d_misalign got=%b exp=%b", i, omis, mis); end
         if (!any || mis) begin
            checks++;
            if (nr !== 0 || ns !== 0) begin failures++; $display("FAIL rnd%0d_notxn got req=%0d stall=%0d exp=0 0", i, nr, ns); end
         end else begin
            checks++;
            if (ohung || ns !== dly + 1 || nr !== dly || oerr !== 1'b0) begin
               failures++; $display("FAIL rnd%0d_timing got stall=%0d req=%0d err=%b hung=%b exp=%0d %0d 0 0", i, ns, nr, oerr, ohung, dly + 1, dly);
            end
            checks++;
            if (oad !== (a & 32'hFFFFFFFC) || owe !== w || !ostab || !oclean) begin
               failures++; $display("FAIL rnd%0d_bus got addr=%h we=%b stable=%b clean=%b exp=%h %b 1 1", i, oad, owe, ostab, oclean, a & 32'hFFFFFFFC, w);
            end
            checks++;
            if (w) begin
               if (obe !== m_be(c, a) || owd !== m_wdata(c, d)) begin
                  failures++; $display("FAIL rnd%0d_store got be=%b wd=%h exp=%b %h", i, obe, owd, m_be(c, a), m_wdata(c, d));
               end
            end else if (obe !== 4'h0 || ord !== m_load(c, a, raw)) begin
               failures++; $display("FAIL rnd%0d_load got be=%b rd=%h exp=0000 %h", i, obe, ord, m_load(c, a, raw));
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_sb();
      test_lh_lhu();
      test_lw_latency();
      test_misalign();
      test_timeout();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
